// File: rtl/ram_bus_scheduler.sv
// Single-port RAM bus scheduler between CPU and DMA: round-robin tie-break, one dead
// HANDOVER cycle on every ownership change, bounded tenure. Optional stats via ARB_STATS_EN.
module ram_bus_scheduler #(
  parameter int MAX_BURST = 16,
  parameter int AW        = 8,
  parameter int DW        = 8
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          CPU_Req,
  output logic          CPU_Gnt,
  input  logic [AW-1:0] CPU_Address,
  input  logic [DW-1:0] CPU_DataOut,
  input  logic          CPU_Cs,
  input  logic          CPU_Wen,
  input  logic          CPU_Oen,
  input  logic          DMA_Req,
  output logic          DMA_Gnt,
  input  logic [AW-1:0] DMA_Address,
  input  logic [DW-1:0] DMA_DataOut,
  input  logic          DMA_Cs,
  input  logic          DMA_Wen,
  input  logic          DMA_Oen,
  output logic [AW-1:0] RAM_Address,
  output logic [DW-1:0] RAM_DataIn,
  output logic          RAM_Cs,
  output logic          RAM_Wen,
  output logic          RAM_Oen,
  output logic [1:0]    Owner,
  output logic [15:0]   Cpu_Grant_Cnt,
  output logic [15:0]   Dma_Grant_Cnt,
  output logic [15:0]   Preempt_Cnt,
  output logic [1:0]    Dbg_State
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CPU_OWN  = 2'd1,
    S_DMA_OWN  = 2'd2,
    S_HANDOVER = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_burst;
  logic          r_last_dma;
  logic          w_burst_top;
  logic          w_enter_cpu;
  logic          w_enter_dma;

  // Handshake: a requester holds Req while it needs the bus; Gnt is registered and
  // rises one cycle after Req is sampled. Bus signals count only while Gnt=1.
  // Tenure also ends once the counter has passed the limit, so a late competitor
  // still preempts an owner that ran long while uncontested.
  assign w_burst_top = (r_burst >= BW'(MAX_BURST - 1));
  assign w_enter_cpu = (w_state_nxt == S_CPU_OWN) && (r_state != S_CPU_OWN);
  assign w_enter_dma = (w_state_nxt == S_DMA_OWN) && (r_state != S_DMA_OWN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Both idle and the dead cycle prefer the side that did not own last.
      S_IDLE, S_HANDOVER: begin
        if (CPU_Req && DMA_Req) w_state_nxt = r_last_dma ? S_CPU_OWN : S_DMA_OWN;
        else if (CPU_Req)       w_state_nxt = S_CPU_OWN;
        else if (DMA_Req)       w_state_nxt = S_DMA_OWN;
        else                    w_state_nxt = S_IDLE;
      end
      S_CPU_OWN: begin
        if (!CPU_Req)                w_state_nxt = DMA_Req ? S_HANDOVER : S_IDLE;
        else if (DMA_Req && w_burst_top) w_state_nxt = S_HANDOVER;
      end
      S_DMA_OWN: begin
        if (!DMA_Req)                w_state_nxt = CPU_Req ? S_HANDOVER : S_IDLE;
        else if (CPU_Req && w_burst_top) w_state_nxt = S_HANDOVER;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_burst    <= '0;
      r_last_dma <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_burst <= '0;
      else if ((r_state == S_CPU_OWN || r_state == S_DMA_OWN) && r_burst != BW'(MAX_BURST))
        r_burst <= r_burst + 1'b1;
      if (w_enter_cpu)      r_last_dma <= 1'b0;
      else if (w_enter_dma) r_last_dma <= 1'b1;
    end
  end

  assign CPU_Gnt   = (r_state == S_CPU_OWN);
  assign DMA_Gnt   = (r_state == S_DMA_OWN);
  assign Owner     = {DMA_Gnt, CPU_Gnt};
  assign Dbg_State = r_state;

  always_comb begin
    RAM_Address = '0;
    RAM_DataIn  = '0;
    RAM_Cs      = 1'b0;
    RAM_Wen     = 1'b1;
    RAM_Oen     = 1'b1;
    if (CPU_Gnt) begin
      RAM_Address = CPU_Address;
      RAM_DataIn  = CPU_DataOut;
      RAM_Cs      = CPU_Cs;
      RAM_Wen     = CPU_Wen;
      RAM_Oen     = CPU_Oen;
    end else if (DMA_Gnt) begin
      RAM_Address = DMA_Address;
      RAM_DataIn  = DMA_DataOut;
      RAM_Cs      = DMA_Cs;
      RAM_Wen     = DMA_Wen;
      RAM_Oen     = DMA_Oen;
    end
  end

`ifdef ARB_STATS_EN
  logic        w_preempt;
  logic [15:0] r_cpu_cnt;
  logic [15:0] r_dma_cnt;
  logic [15:0] r_pre_cnt;

  // Leaving a tenure for HANDOVER while the owner still requests is a preemption.
  assign w_preempt = (w_state_nxt == S_HANDOVER) &&
                     ((r_state == S_CPU_OWN && CPU_Req) || (r_state == S_DMA_OWN && DMA_Req));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cpu_cnt <= '0;
      r_dma_cnt <= '0;
      r_pre_cnt <= '0;
    end else begin
      if (w_enter_cpu && r_cpu_cnt != 16'hFFFF) r_cpu_cnt <= r_cpu_cnt + 16'd1;
      if (w_enter_dma && r_dma_cnt != 16'hFFFF) r_dma_cnt <= r_dma_cnt + 16'd1;
      if (w_preempt   && r_pre_cnt != 16'hFFFF) r_pre_cnt <= r_pre_cnt + 16'd1;
    end
  end

  assign Cpu_Grant_Cnt = r_cpu_cnt;
  assign Dma_Grant_Cnt = r_dma_cnt;
  assign Preempt_Cnt   = r_pre_cnt;
`else
  assign Cpu_Grant_Cnt = '0;
  assign Dma_Grant_Cnt = '0;
  assign Preempt_Cnt   = '0;
`endif

endmodule

// File: tb/tb_ram_bus_scheduler.sv
// Directed table-driven bench for ram_bus_scheduler (MAX_BURST=4), plus hand-written
// reset, handover and asynchronous-reset sequences.
module tb_ram_bus_scheduler;

  logic        Clk;
  logic        Rst_n;
  logic        CPU_Req, CPU_Gnt, CPU_Cs, CPU_Wen, CPU_Oen;
  logic [7:0]  CPU_Address, CPU_DataOut;
  logic        DMA_Req, DMA_Gnt, DMA_Cs, DMA_Wen, DMA_Oen;
  logic [7:0]  DMA_Address, DMA_DataOut;
  logic [7:0]  RAM_Address, RAM_DataIn;
  logic        RAM_Cs, RAM_Wen, RAM_Oen;
  logic [1:0]  Owner, Dbg_State;
  logic [15:0] Cpu_Grant_Cnt, Dma_Grant_Cnt, Preempt_Cnt;

  int n_cmp  = 0;
  int n_miss = 0;

  typedef struct {
    logic       cpu_req;
    logic       dma_req;
    logic       cpu_cs;
    logic       cg;
    logic       dg;
    logic [1:0] own;
    logic       cs;
    logic [7:0] addr;
    logic       wen;
  } vec_t;

  vec_t vq[$];

  ram_bus_scheduler #(.MAX_BURST(4), .AW(8), .DW(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .CPU_Req(CPU_Req), .CPU_Gnt(CPU_Gnt), .CPU_Address(CPU_Address),
    .CPU_DataOut(CPU_DataOut), .CPU_Cs(CPU_Cs), .CPU_Wen(CPU_Wen), .CPU_Oen(CPU_Oen),
    .DMA_Req(DMA_Req), .DMA_Gnt(DMA_Gnt), .DMA_Address(DMA_Address),
    .DMA_DataOut(DMA_DataOut), .DMA_Cs(DMA_Cs), .DMA_Wen(DMA_Wen), .DMA_Oen(DMA_Oen),
    .RAM_Address(RAM_Address), .RAM_DataIn(RAM_DataIn), .RAM_Cs(RAM_Cs),
    .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen), .Owner(Owner),
    .Cpu_Grant_Cnt(Cpu_Grant_Cnt), .Dma_Grant_Cnt(Dma_Grant_Cnt),
    .Preempt_Cnt(Preempt_Cnt), .Dbg_State(Dbg_State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic cr, input logic dr, input logic ccs, input logic cg,
                     input logic dg, input logic [1:0] own, input logic cs,
                     input logic [7:0] addr, input logic wen);
    vec_t v;
    v.cpu_req = cr; v.dma_req = dr; v.cpu_cs = ccs;
    v.cg = cg; v.dg = dg; v.own = own; v.cs = cs; v.addr = addr; v.wen = wen;
    vq.push_back(v);
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " cpu_gnt"}, 16'(CPU_Gnt), 16'd0);
    chk({tag, " dma_gnt"}, 16'(DMA_Gnt), 16'd0);
    chk({tag, " owner"},   16'(Owner),   16'd0);
    chk({tag, " ram_cs"},  16'(RAM_Cs),  16'd0);
    chk({tag, " ram_wen"}, 16'(RAM_Wen), 16'd1);
    chk({tag, " ram_oen"}, 16'(RAM_Oen), 16'd1);
  endtask

  initial begin
    logic [7:0] exp_data;
    logic       exp_oen;
    Rst_n = 1'b0;
    CPU_Req = 1'b0; CPU_Cs = 1'b1; CPU_Wen = 1'b0; CPU_Oen = 1'b1;
    CPU_Address = 8'h3A; CPU_DataOut = 8'h11;
    DMA_Req = 1'b0; DMA_Cs = 1'b1; DMA_Wen = 1'b1; DMA_Oen = 1'b0;
    DMA_Address = 8'hC5; DMA_DataOut = 8'h22;

    //  cr dr ccs | cg dg own cs addr wen
    add(0, 0, 1,  0, 0, 2'b00, 0, 8'h00, 1);  // idle after reset
    add(1, 0, 1,  1, 0, 2'b01, 1, 8'h3A, 0);  // CPU alone, DMA_Cs ignored
    add(0, 0, 1,  0, 0, 2'b00, 0, 8'h00, 1);  // release to idle
    add(1, 1, 1,  0, 1, 2'b10, 1, 8'hC5, 1);  // tie, last=CPU -> DMA
    add(1, 1, 1,  0, 1, 2'b10, 1, 8'hC5, 1);
    add(1, 1, 1,  0, 1, 2'b10, 1, 8'hC5, 1);
    add(1, 1, 1,  0, 1, 2'b10, 1, 8'hC5, 1);  // 4th owned cycle
    add(1, 1, 1,  0, 0, 2'b00, 0, 8'h00, 1);  // preempted -> handover
    add(1, 1, 1,  1, 0, 2'b01, 1, 8'h3A, 0);  // CPU granted
    add(0, 1, 1,  0, 0, 2'b00, 0, 8'h00, 1);  // CPU release -> handover
    add(0, 1, 1,  0, 1, 2'b10, 1, 8'hC5, 1);  // DMA returns
    add(0, 0, 1,  0, 0, 2'b00, 0, 8'h00, 1);  // DMA release -> idle
    add(1, 0, 1,  1, 0, 2'b01, 1, 8'hA3 ^ 8'h99, 0);  // 3rd CPU tenure
    add(1, 0, 0,  1, 0, 2'b01, 0, 8'h3A, 0);  // owner Cs low wins over DMA_Cs
    add(0, 1, 1,  0, 0, 2'b00, 0, 8'h00, 1);  // release with DMA pending
    add(0, 0, 1,  0, 0, 2'b00, 0, 8'h00, 1);  // DMA withdrew in handover

    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge Clk);
      CPU_Req = vq[i].cpu_req;
      DMA_Req = vq[i].dma_req;
      CPU_Cs  = vq[i].cpu_cs;
      @(posedge Clk);
      #1;
      exp_data = (vq[i].own == 2'b01) ? 8'h11 : (vq[i].own == 2'b10) ? 8'h22 : 8'h00;
      exp_oen  = (vq[i].own == 2'b10) ? 1'b0 : 1'b1;
      chk($sformatf("v%0d cpu_gnt", i),  16'(CPU_Gnt),     16'(vq[i].cg));
      chk($sformatf("v%0d dma_gnt", i),  16'(DMA_Gnt),     16'(vq[i].dg));
      chk($sformatf("v%0d owner", i),    16'(Owner),       16'(vq[i].own));
      chk($sformatf("v%0d ram_cs", i),   16'(RAM_Cs),      16'(vq[i].cs));
      chk($sformatf("v%0d ram_addr", i), 16'(RAM_Address), 16'(vq[i].addr));
      chk($sformatf("v%0d ram_wen", i),  16'(RAM_Wen),     16'(vq[i].wen));
      chk($sformatf("v%0d ram_data", i), 16'(RAM_DataIn),  16'(exp_data));
      chk($sformatf("v%0d ram_oen", i),  16'(RAM_Oen),     16'(exp_oen));
    end

`ifdef ARB_STATS_EN
    chk("stats cpu_grants", Cpu_Grant_Cnt, 16'd3);
    chk("stats dma_grants", Dma_Grant_Cnt, 16'd2);
    chk("stats preempts",   Preempt_Cnt,   16'd1);
`else
    chk("stats cpu_grants", Cpu_Grant_Cnt, 16'd0);
    chk("stats dma_grants", Dma_Grant_Cnt, 16'd0);
    chk("stats preempts",   Preempt_Cnt,   16'd0);
`endif

    // Reset held with both requests pending.
    @(negedge Clk);
    Rst_n = 1'b0; CPU_Req = 1'b1; DMA_Req = 1'b1; CPU_Cs = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk_idle_bus("rst_hold");
    chk("rst_hold cpu_cnt", Cpu_Grant_Cnt, 16'd0);
    chk("rst_hold pre_cnt", Preempt_Cnt,   16'd0);

    // Both requesting out of reset: CPU first, 3 cycles, dead cycle, then DMA.
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("seqb cpu_own%0d gnt", k), 16'(CPU_Gnt), 16'd1);
      chk($sformatf("seqb cpu_own%0d addr", k), 16'(RAM_Address), 16'h3A);
    end
    @(negedge Clk);
    CPU_Req = 1'b0;
    @(posedge Clk);
    #1;
    chk_idle_bus("seqb handover");
    chk("seqb handover state", 16'(Dbg_State), 16'd3);
    @(posedge Clk);
    #1;
    chk("seqb dma_gnt", 16'(DMA_Gnt), 16'd1);
    chk("seqb dma_cs", 16'(RAM_Cs), 16'd1);
    chk("seqb dma_addr", 16'(RAM_Address), 16'hC5);

    // DMA write in flight, reset pulsed mid-cycle.
    @(negedge Clk);
    DMA_Wen = 1'b0; CPU_Req = 1'b1;
    @(posedge Clk);
    #1;
    chk("seqc write wen", 16'(RAM_Wen), 16'd0);
    chk("seqc write cs", 16'(RAM_Cs), 16'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk_idle_bus("seqc async_rst");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("seqc tie cpu_gnt", 16'(CPU_Gnt), 16'd1);
    chk("seqc tie owner", 16'(Owner), 16'd1);
    chk("seqc tie dma_gnt", 16'(DMA_Gnt), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
